// File: rtl/rwc_irq_bank.sv
// ----------------------------------------------------------------------------
// rwc_irq_bank
//
// Bank of NCH sticky status registers, each paired with a mask register,
// feeding per-channel and global interrupt lines.
//
// Event logic sets status bits. The CPU clears them by writing 1s to the
// status register (write-1-to-clear). When CLR_ON_RD is set, a status read
// also clears the bits it returned. A logic set always beats a clear in the
// same cycle. Writes never set a status bit.
//
// Address map (AW-bit arithmetic, wraps naturally):
//   BASE_ADDR + 2k     : STAT[k]  (R / W1C)
//   BASE_ADDR + 2k + 1 : MASK[k]  (RW, 1 = masked)
//   anything else      : writes ignored, reads return 0
//
// CPU bus handshake: there is no back-pressure. A write is accepted in every
// cycle i_wen is high. A read is accepted in every cycle i_ren is high; in the
// following cycle o_rvld pulses high for exactly one cycle and o_rdata holds
// the register value as it was in the request cycle. When no read returns,
// o_rdata is 0. A read and a write to the same address in the same cycle
// return the pre-write value.
//
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_wen, i_ren     CPU write / read strobes
//   i_addr, i_wdata  CPU address and write data
//   o_rdata, o_rvld  registered read data and its one-cycle valid pulse
//   i_evt            event inputs, channel k in bits [k*DW +: DW]
//   o_stat           status register contents, same packing as i_evt
//   o_irq_ch         registered per-channel interrupt
//   o_irq            registered OR of the per-channel interrupts
// ----------------------------------------------------------------------------
module rwc_irq_bank #(
    parameter int            DW        = 8,
    parameter int            AW        = 8,
    parameter int            NCH       = 4,
    parameter logic [AW-1:0] BASE_ADDR = '0,
    parameter logic [DW-1:0] EDGE_MODE = '0,
    parameter logic          CLR_ON_RD = 1'b0,
    parameter logic [DW-1:0] MASK_RST  = '1,
    parameter logic [DW-1:0] STAT_RST  = '0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_wen,
    input  logic              i_ren,
    input  logic [AW-1:0]     i_addr,
    input  logic [DW-1:0]     i_wdata,
    output logic [DW-1:0]     o_rdata,
    output logic              o_rvld,
    input  logic [NCH*DW-1:0] i_evt,
    output logic [NCH*DW-1:0] o_stat,
    output logic [NCH-1:0]    o_irq_ch,
    output logic              o_irq
);

    // Register state, one DW-wide row per channel.
    logic [NCH-1:0][DW-1:0] stat_q;
    logic [NCH-1:0][DW-1:0] mask_q;
    logic [NCH-1:0][DW-1:0] evt_d_q;

    // Next-state values.
    logic [NCH-1:0][DW-1:0] stat_nx;
    logic [NCH-1:0][DW-1:0] mask_nx;

    // Address decode and interrupt terms.
    logic [NCH-1:0] stat_hit;
    logic [NCH-1:0] mask_hit;
    logic [NCH-1:0] irq_ch_nx;

    logic [DW-1:0]  rd_mux;

    // ------------------------------------------------------------------------
    // Per-channel datapath
    // ------------------------------------------------------------------------
    for (genvar k = 0; k < NCH; k++) begin : g_ch
        localparam logic [AW-1:0] STAT_ADDR = BASE_ADDR + AW'(2 * k);
        localparam logic [AW-1:0] MASK_ADDR = BASE_ADDR + AW'(2 * k + 1);

        logic [DW-1:0] evt;
        logic [DW-1:0] set;
        logic [DW-1:0] wr_clr;
        logic [DW-1:0] rd_clr;

        assign stat_hit[k] = (i_addr == STAT_ADDR);
        assign mask_hit[k] = (i_addr == MASK_ADDR);

        assign evt = i_evt[k*DW +: DW];

        // Edge bits are suppressed while the history flop is already high;
        // level bits ignore the history flop entirely.
        assign set = evt & ~(evt_d_q[k] & EDGE_MODE);

        assign wr_clr = (i_wen && stat_hit[k]) ? i_wdata : '0;

        // Clear-on-read removes exactly the bits that were returned, which are
        // the bits currently set.
        assign rd_clr = (CLR_ON_RD && i_ren && stat_hit[k]) ? stat_q[k] : '0;

        // Set is OR-ed in last so it overrides both clear sources.
        assign stat_nx[k] = set | (stat_q[k] & ~wr_clr & ~rd_clr);

        assign mask_nx[k] = (i_wen && mask_hit[k]) ? i_wdata : mask_q[k];

        // Interrupt follows the registered status and mask, giving one cycle
        // from status set to interrupt assertion.
        assign irq_ch_nx[k] = |(stat_q[k] & ~mask_q[k]);

        assign o_stat[k*DW +: DW] = stat_q[k];
    end

    // ------------------------------------------------------------------------
    // Read data select: addresses are distinct, so at most one term is live.
    // Unmapped addresses fall through to zero.
    // ------------------------------------------------------------------------
    always_comb begin
        rd_mux = '0;
        for (int k = 0; k < NCH; k++) begin
            if (stat_hit[k]) begin
                rd_mux = rd_mux | stat_q[k];
            end
            if (mask_hit[k]) begin
                rd_mux = rd_mux | mask_q[k];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Status, mask and edge-history registers
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            stat_q  <= {NCH{STAT_RST}};
            mask_q  <= {NCH{MASK_RST}};
            // History starts at 0 so an event already high when reset is
            // released counts as a rising edge on the first clock.
            evt_d_q <= '0;
        end else begin
            stat_q  <= stat_nx;
            mask_q  <= mask_nx;
            evt_d_q <= i_evt;
        end
    end

    // ------------------------------------------------------------------------
    // Read return path
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_rvld  <= 1'b0;
            o_rdata <= '0;
        end else begin
            o_rvld  <= i_ren;
            o_rdata <= i_ren ? rd_mux : '0;
        end
    end

    // ------------------------------------------------------------------------
    // Interrupt outputs: o_irq is built from the same next value as o_irq_ch
    // so the two always change on the same edge.
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_irq_ch <= '0;
            o_irq    <= 1'b0;
        end else begin
            o_irq_ch <= irq_ch_nx;
            o_irq    <= |irq_ch_nx;
        end
    end

endmodule

// File: tb/tb_rwc_irq_bank.sv
// ----------------------------------------------------------------------------
// tb_rwc_irq_bank
//
// Two instances share one stimulus stream: index 0 keeps status on read,
// index 1 clears status on read. A register-level model predicts every output
// of both instances each cycle; directed literal checks pin the model.
// ----------------------------------------------------------------------------
module tb_rwc_irq_bank;

    localparam int         NCH  = 2;
    localparam logic [7:0] BASE = 8'h10;

    // ------------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        wen;
    logic        ren;
    logic [7:0]  addr;
    logic [7:0]  wdata;
    logic [15:0] evt;

    logic [1:0][7:0]  rdata;
    logic [1:0]       rvld;
    logic [1:0][15:0] stat;
    logic [1:0][1:0]  irq_ch;
    logic [1:0]       irq;

    rwc_irq_bank #(
        .DW(8), .AW(8), .NCH(NCH), .BASE_ADDR(BASE), .EDGE_MODE(8'h0F),
        .CLR_ON_RD(1'b0), .MASK_RST(8'hFF), .STAT_RST(8'h00)
    ) dut_keep (
        .i_clk(clk), .i_rst_n(rst_n), .i_wen(wen), .i_ren(ren),
        .i_addr(addr), .i_wdata(wdata), .o_rdata(rdata[0]), .o_rvld(rvld[0]),
        .i_evt(evt), .o_stat(stat[0]), .o_irq_ch(irq_ch[0]), .o_irq(irq[0])
    );

    rwc_irq_bank #(
        .DW(8), .AW(8), .NCH(NCH), .BASE_ADDR(BASE), .EDGE_MODE(8'h0F),
        .CLR_ON_RD(1'b1), .MASK_RST(8'hFF), .STAT_RST(8'h00)
    ) dut_cor (
        .i_clk(clk), .i_rst_n(rst_n), .i_wen(wen), .i_ren(ren),
        .i_addr(addr), .i_wdata(wdata), .o_rdata(rdata[1]), .o_rvld(rvld[1]),
        .i_evt(evt), .o_stat(stat[1]), .o_irq_ch(irq_ch[1]), .o_irq(irq[1])
    );

    // ------------------------------------------------------------------------
    // Scoreboard bookkeeping
    // ------------------------------------------------------------------------
    int   n_checks = 0;
    int   n_errors = 0;
    logic cmp_en   = 1'b0;

    logic [7:0] exp_q0[$];
    logic [7:0] exp_q1[$];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------------
    logic [7:0]  edge_mode = 8'h0F;
    logic [7:0]  m_stat [2][NCH];
    logic [7:0]  m_mask [2][NCH];
    logic [15:0] m_evt_d;
    logic [7:0]  m_rdata [2];
    logic        m_rvld [2];
    logic [1:0]  m_irq_ch [2];
    logic        m_irq [2];

    int          mo;
    logic [1:0]  mi;
    logic        e;
    logic        rise;
    logic        s;

    // Offset of an address from the base, or -1 when it hits no register.
    // Even offsets are status registers, odd offsets are masks.
    function automatic int reg_offset(input logic [7:0] a);
        int off;
        off = int'(a) - int'(BASE);
        if (off < 0 || off >= 2 * NCH) return -1;
        return off;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) begin
                for (int k = 0; k < NCH; k++) begin
                    m_stat[d][k] = 8'h00;
                    m_mask[d][k] = 8'hFF;
                end
                m_rdata[d]  = 8'h00;
                m_rvld[d]   = 1'b0;
                m_irq_ch[d] = 2'b00;
                m_irq[d]    = 1'b0;
            end
            m_evt_d = 16'h0000;
            exp_q0.delete();
            exp_q1.delete();
        end else begin
            mo = reg_offset(addr);
            for (int d = 0; d < 2; d++) begin
                // Reads and interrupts see the state before this edge.
                m_rvld[d]  = ren;
                m_rdata[d] = 8'h00;
                if (ren && mo >= 0) begin
                    m_rdata[d] = (mo % 2 == 1) ? m_mask[d][mo/2] : m_stat[d][mo/2];
                end
                if (ren) begin
                    if (d == 0) exp_q0.push_back(m_rdata[d]);
                    else        exp_q1.push_back(m_rdata[d]);
                end

                mi = 2'b00;
                for (int k = 0; k < NCH; k++) begin
                    mi[k] = |(m_stat[d][k] & ~m_mask[d][k]);
                end
                m_irq_ch[d] = mi;
                m_irq[d]    = |mi;

                // Status bits in priority order: set, write-1-clear, read-clear.
                for (int k = 0; k < NCH; k++) begin
                    for (int b = 0; b < 8; b++) begin
                        e    = evt[k*8+b];
                        rise = e && !m_evt_d[k*8+b];
                        s    = edge_mode[b] ? rise : e;
                        if (s) begin
                            m_stat[d][k][b] = 1'b1;
                        end else if (wen && mo == 2 * k && wdata[b]) begin
                            m_stat[d][k][b] = 1'b0;
                        end else if (d == 1 && ren && mo == 2 * k) begin
                            m_stat[d][k][b] = 1'b0;
                        end
                    end
                    if (wen && mo == 2 * k + 1) begin
                        m_mask[d][k] = wdata;
                    end
                end
            end
            m_evt_d = evt;
        end
    end

    // ------------------------------------------------------------------------
    // Per-cycle compare against the model
    // ------------------------------------------------------------------------
    always @(negedge clk) begin
        if (cmp_en) begin
            for (int d = 0; d < 2; d++) begin
                check($sformatf("dut%0d rvld", d), 32'(rvld[d]), 32'(m_rvld[d]));
                check($sformatf("dut%0d rdata", d), 32'(rdata[d]), 32'(m_rdata[d]));
                check($sformatf("dut%0d stat", d), 32'(stat[d]),
                      32'({m_stat[d][1], m_stat[d][0]}));
                check($sformatf("dut%0d irq_ch", d), 32'(irq_ch[d]), 32'(m_irq_ch[d]));
                check($sformatf("dut%0d irq", d), 32'(irq[d]), 32'(m_irq[d]));
            end
            if (rvld[0]) begin
                check("dut0 read pending", 32'(exp_q0.size() > 0), 32'd1);
                if (exp_q0.size() > 0) check("dut0 read sb", 32'(rdata[0]), 32'(exp_q0.pop_front()));
            end
            if (rvld[1]) begin
                check("dut1 read pending", 32'(exp_q1.size() > 0), 32'd1);
                if (exp_q1.size() > 0) check("dut1 read sb", 32'(rdata[1]), 32'(exp_q1.pop_front()));
            end
        end
    end

    // ------------------------------------------------------------------------
    // Driver tasks: inputs change 1 time unit after the rising edge.
    // ------------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        wen   = 1'b1;
        addr  = a;
        wdata = d;
        tick();
        wen   = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a);
        ren  = 1'b1;
        addr = a;
        tick();
        ren  = 1'b0;
    endtask

    // ------------------------------------------------------------------------
    // Directed stimulus with literal expectations
    // ------------------------------------------------------------------------
    initial begin
        rst_n = 1'b0;
        wen   = 1'b0;
        ren   = 1'b0;
        addr  = 8'h00;
        wdata = 8'h00;
        evt   = 16'h0000;
        repeat (3) @(posedge clk);
        cmp_en = 1'b1;
        #1 rst_n = 1'b1;

        // Reset state and first reads.
        for (int d = 0; d < 2; d++) begin
            check($sformatf("dut%0d reset stat", d), 32'(stat[d]), 32'h0000);
            check($sformatf("dut%0d reset irq", d), 32'(irq[d]), 32'h0);
        end
        rd(8'h10);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("dut%0d rvld stat0", d), 32'(rvld[d]), 32'h1);
            check($sformatf("dut%0d rdata stat0", d), 32'(rdata[d]), 32'h00);
        end
        rd(8'h11);
        for (int d = 0; d < 2; d++) check($sformatf("dut%0d rdata mask0", d), 32'(rdata[d]), 32'hFF);
        tick();
        for (int d = 0; d < 2; d++) begin
            check($sformatf("dut%0d rvld drop", d), 32'(rvld[d]), 32'h0);
            check($sformatf("dut%0d irq idle", d), 32'(irq[d]), 32'h0);
        end

        // One-cycle pulse on an edge bit, then unmask it.
        evt = 16'h0001;
        tick();
        evt = 16'h0000;
        for (int d = 0; d < 2; d++) check($sformatf("dut%0d pulse stat0", d), 32'(stat[d][7:0]), 32'h01);
        wr(8'h11, 8'hFE);
        for (int d = 0; d < 2; d++) check($sformatf("dut%0d irq 1 after mask", d), 32'(irq[d]), 32'h0);
        tick();
        for (int d = 0; d < 2; d++) begin
            check($sformatf("dut%0d irq_ch 2 after mask", d), 32'(irq_ch[d]), 32'h1);
            check($sformatf("dut%0d irq 2 after mask", d), 32'(irq[d]), 32'h1);
        end
        wr(8'h10, 8'h01);
        tick();
        for (int d = 0; d < 2; d++) begin
            check($sformatf("dut%0d w1c bit0", d), 32'(stat[d][7:0]), 32'h00);
            check($sformatf("dut%0d irq after w1c", d), 32'(irq[d]), 32'h0);
        end

        // Edge bit held high for five cycles, cleared during the hold.
        evt = 16'h0002;
        tick();
        for (int d = 0; d < 2; d++) check($sformatf("dut%0d edge set", d), 32'(stat[d][7:0]), 32'h02);
        tick();
        wr(8'h10, 8'h02);
        for (int d = 0; d < 2; d++) check($sformatf("dut%0d edge w1c", d), 32'(stat[d][7:0]), 32'h00);
        tick();
        tick();
        for (int d = 0; d < 2; d++) check($sformatf("dut%0d edge no reset", d), 32'(stat[d][7:0]), 32'h00);
        evt = 16'h0000;
        tick();

        // Level bit: set and clear in the same cycle, set wins.
        wr(8'h11, 8'hEE);
        evt = 16'h0010;
        wr(8'h10, 8'h10);
        for (int d = 0; d < 2; d++) check($sformatf("dut%0d level set wins", d), 32'(stat[d][7:0]), 32'h10);
        wr(8'h10, 8'h10);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("dut%0d level held", d), 32'(stat[d][7:0]), 32'h10);
            check($sformatf("dut%0d level irq", d), 32'(irq[d]), 32'h1);
        end
        evt = 16'h0000;
        wr(8'h10, 8'h10);
        for (int d = 0; d < 2; d++) check($sformatf("dut%0d level cleared", d), 32'(stat[d][7:0]), 32'h00);
        tick();
        for (int d = 0; d < 2; d++) check($sformatf("dut%0d level irq drop", d), 32'(irq[d]), 32'h0);

        // Clear-on-read on channel 1.
        evt = 16'h8100;
        tick();
        evt = 16'h0000;
        for (int d = 0; d < 2; d++) check($sformatf("dut%0d stat1 armed", d), 32'(stat[d][15:8]), 32'h81);
        rd(8'h12);
        for (int d = 0; d < 2; d++) check($sformatf("dut%0d cor rdata", d), 32'(rdata[d]), 32'h81);
        check("dut0 stat1 kept", 32'(stat[0][15:8]), 32'h81);
        check("dut1 stat1 cleared", 32'(stat[1][15:8]), 32'h00);
        evt = 16'h8100;
        tick();
        evt = 16'h8000;
        rd(8'h12);
        evt = 16'h0000;
        for (int d = 0; d < 2; d++) check($sformatf("dut%0d cor+set rdata", d), 32'(rdata[d]), 32'h81);
        check("dut0 stat1 after set+read", 32'(stat[0][15:8]), 32'h81);
        check("dut1 stat1 after set+read", 32'(stat[1][15:8]), 32'h80);
        wr(8'h12, 8'hFF);
        for (int d = 0; d < 2; d++) check($sformatf("dut%0d stat1 w1c all", d), 32'(stat[d]), 32'h0000);

        // Unmapped access, then reset in the middle of a read return.
        wr(8'h14, 8'hAA);
        for (int d = 0; d < 2; d++) check($sformatf("dut%0d unmapped write", d), 32'(stat[d]), 32'h0000);
        rd(8'h13);
        for (int d = 0; d < 2; d++) check($sformatf("dut%0d mask1 intact", d), 32'(rdata[d]), 32'hFF);
        rd(8'h14);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("dut%0d unmapped rvld", d), 32'(rvld[d]), 32'h1);
            check($sformatf("dut%0d unmapped rdata", d), 32'(rdata[d]), 32'h00);
        end
        rd(8'h11);
        for (int d = 0; d < 2; d++) check($sformatf("dut%0d mask0 before reset", d), 32'(rdata[d]), 32'hEE);
        evt = 16'h0004;
        #2 rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("dut%0d async rvld", d), 32'(rvld[d]), 32'h0);
            check($sformatf("dut%0d async rdata", d), 32'(rdata[d]), 32'h00);
            check($sformatf("dut%0d async stat", d), 32'(stat[d]), 32'h0000);
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        for (int d = 0; d < 2; d++) check($sformatf("dut%0d edge at release", d), 32'(stat[d][7:0]), 32'h04);
        evt = 16'h0000;
        rd(8'h11);
        for (int d = 0; d < 2; d++) check($sformatf("dut%0d mask0 reset", d), 32'(rdata[d]), 32'hFF);
        rd(8'h10);
        for (int d = 0; d < 2; d++) check($sformatf("dut%0d stat0 read", d), 32'(rdata[d]), 32'h04);
        check("dut0 stat0 kept", 32'(stat[0][7:0]), 32'h04);
        check("dut1 stat0 cleared", 32'(stat[1][7:0]), 32'h00);
        tick();
        tick();

        check("dut0 read queue drained", 32'(exp_q0.size()), 32'd0);
        check("dut1 read queue drained", 32'(exp_q1.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
